// File: rtl/issue_sched_pkg.sv
// Shared opcode/funct encodings and register constants for the issue scheduler.
package issue_sched_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J_AL  = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_ADD   = 6'h20;

    localparam logic [4:0] REG_RA   = 5'd31;

endpackage

// File: rtl/issue_sched_ins_class.sv
// Combinational instruction classifier: control/memory class, destination and sources.
module ins_class
    import issue_sched_pkg::*;
(
    input  logic [31:0] ins,
    output logic        is_ctrl,
    output logic        is_mem,
    output logic        has_dst,
    output logic [4:0]  dst,
    output logic [4:0]  src_a,
    output logic [4:0]  src_b,
    output logic        has_b
);

    logic [5:0] op;
    logic [5:0] funct;
    logic       is_jr;
    logic       is_rtype;
    logic       unused_shamt;

    assign op           = ins[31:26];
    assign funct        = ins[5:0];
    assign is_jr        = (op == OP_RTYPE) && (funct == FN_JR);
    assign is_rtype     = (op == OP_RTYPE) && !is_jr;
    assign unused_shamt = ^ins[10:6];

    // Decode class, destination and source registers from opcode fields.
    always_comb begin
        is_ctrl = is_jr || (op == OP_J_AL) || (op == OP_BEQ);
        is_mem  = (op == OP_LW) || (op == OP_SW);
        has_dst = 1'b0;
        dst     = 5'd0;
        src_a   = ins[25:21];
        src_b   = ins[20:16];
        has_b   = is_rtype || (op == OP_SW) || (op == OP_BEQ);
        if (is_rtype) begin
            has_dst = 1'b1;
            dst     = ins[15:11];
        end else if ((op == OP_ADDI) || (op == OP_LW)) begin
            has_dst = 1'b1;
            dst     = ins[20:16];
        end else if (op == OP_J_AL) begin
            has_dst = 1'b1;
            dst     = REG_RA;
        end
    end

endmodule

// File: rtl/issue_sched.sv
// Dual-issue instruction queue and scheduler between fetch and register read.
//
//   state      | meaning
//   -----------+---------------------------------------------------------
//   ST_ISSUE   | normal operation, issue 0..2 instructions per cycle
//   ST_WAIT_BR | control instruction in flight; no issue until resolved
module issue_sched
    import issue_sched_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          f_valid,
    input  logic [31:0]   f_ins0,
    input  logic [31:0]   f_ins1,
    input  logic [31:0]   f_pc,
    output logic          f_ready,
    input  logic          dual_en,
    input  logic          ex_stall,
    input  logic          br_resolve,
    input  logic          br_taken,
    output logic          iss_v0,
    output logic [31:0]   iss_ins0,
    output logic [31:0]   iss_pc0,
    output logic          iss_v1,
    output logic [31:0]   iss_ins1,
    output logic [31:0]   iss_pc1,
    output logic [AW:0]   count
);

    typedef enum logic {ST_ISSUE = 1'b0, ST_WAIT_BR = 1'b1} state_t;

    state_t        state;
    logic [63:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] rd_ptr1;
    logic [63:0]   ent0;
    logic [63:0]   ent1;

    logic          c0_is_ctrl, c0_is_mem, c0_has_dst, c0_has_b;
    logic [4:0]    c0_dst, c0_src_a, c0_src_b;
    logic          c1_is_ctrl, c1_is_mem, c1_has_dst, c1_has_b;
    logic [4:0]    c1_dst, c1_src_a, c1_src_b;
    logic          unused_c0;

    logic          flush;
    logic          resume;
    logic          enq;
    logic          take0;
    logic          take1;
    logic          hazard_ok;
    logic [AW:0]   n_iss;

    assign rd_ptr1   = rd_ptr + AW'(1);
    assign ent0      = mem[rd_ptr];
    assign ent1      = mem[rd_ptr1];
    assign f_ready   = (count <= (AW+1)'(DEPTH - 2));
    assign flush     = (state == ST_WAIT_BR) && br_resolve && br_taken;
    assign resume    = (state == ST_WAIT_BR) && br_resolve && !br_taken;
    assign enq       = f_valid && f_ready && !flush;
    assign unused_c0 = c0_is_mem ^ c0_has_b ^ (^c0_src_a) ^ (^c0_src_b);

    ins_class u_cls0 (
        .ins     (ent0[31:0]),
        .is_ctrl (c0_is_ctrl),
        .is_mem  (c0_is_mem),
        .has_dst (c0_has_dst),
        .dst     (c0_dst),
        .src_a   (c0_src_a),
        .src_b   (c0_src_b),
        .has_b   (c0_has_b)
    );

    ins_class u_cls1 (
        .ins     (ent1[31:0]),
        .is_ctrl (c1_is_ctrl),
        .is_mem  (c1_is_mem),
        .has_dst (c1_has_dst),
        .dst     (c1_dst),
        .src_a   (c1_src_a),
        .src_b   (c1_src_b),
        .has_b   (c1_has_b)
    );

    // Issue decision for this cycle; a dest of $0 on the head blocks pairing.
    always_comb begin
        hazard_ok = !c0_has_dst ||
                    ((c0_dst != 5'd0) &&
                     (c0_dst != c1_src_a) &&
                     (!c1_has_b   || (c0_dst != c1_src_b)) &&
                     (!c1_has_dst || (c0_dst != c1_dst)));
        take0 = (state == ST_ISSUE) && !ex_stall && (count != '0);
        take1 = take0 && (count >= (AW+1)'(2)) && dual_en &&
                !c0_is_ctrl && !c1_is_ctrl && !c1_is_mem && hazard_ok;
        n_iss = (AW+1)'(take0) + (AW+1)'(take1);
    end

    // Queue storage; contents need no reset.
    always_ff @(posedge clk) begin
        if (enq) begin
            mem[wr_ptr]          <= {f_pc, f_ins0};
            mem[wr_ptr + AW'(1)] <= {f_pc + 32'd1, f_ins1};
        end
    end

    // Pointers, occupancy, FSM and registered issue outputs; flush overrides stall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_ISSUE;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            iss_v0   <= 1'b0;
            iss_ins0 <= '0;
            iss_pc0  <= '0;
            iss_v1   <= 1'b0;
            iss_ins1 <= '0;
            iss_pc1  <= '0;
        end else if (flush) begin
            state    <= ST_ISSUE;
            rd_ptr   <= wr_ptr;
            count    <= '0;
            iss_v0   <= 1'b0;
            iss_ins0 <= '0;
            iss_pc0  <= '0;
            iss_v1   <= 1'b0;
            iss_ins1 <= '0;
            iss_pc1  <= '0;
        end else begin
            if (enq) begin
                wr_ptr <= wr_ptr + AW'(2);
            end
            count <= count + (enq ? (AW+1)'(2) : '0) - n_iss;
            if (resume) begin
                state <= ST_ISSUE;
            end else if (take0 && c0_is_ctrl) begin
                state <= ST_WAIT_BR;
            end
            if (!ex_stall) begin
                rd_ptr   <= rd_ptr + n_iss[AW-1:0];
                iss_v0   <= take0;
                iss_ins0 <= take0 ? ent0[31:0]  : '0;
                iss_pc0  <= take0 ? ent0[63:32] : '0;
                iss_v1   <= take1;
                iss_ins1 <= take1 ? ent1[31:0]  : '0;
                iss_pc1  <= take1 ? ent1[63:32] : '0;
            end
        end
    end

endmodule

// File: tb/tb_issue_sched.sv
// Directed bench for issue_sched: pairing, hazards, branches, full queue, wrap and reset.
module tb_issue_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic        f_valid;
    logic [31:0] f_ins0;
    logic [31:0] f_ins1;
    logic [31:0] f_pc;
    logic        f_ready;
    logic        dual_en;
    logic        ex_stall;
    logic        br_resolve;
    logic        br_taken;
    logic        iss_v0;
    logic [31:0] iss_ins0;
    logic [31:0] iss_pc0;
    logic        iss_v1;
    logic [31:0] iss_ins1;
    logic [31:0] iss_pc1;
    logic [3:0]  count;

    int checks   = 0;
    int failures = 0;

    issue_sched #(.DEPTH(8), .AW(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .f_valid    (f_valid),
        .f_ins0     (f_ins0),
        .f_ins1     (f_ins1),
        .f_pc       (f_pc),
        .f_ready    (f_ready),
        .dual_en    (dual_en),
        .ex_stall   (ex_stall),
        .br_resolve (br_resolve),
        .br_taken   (br_taken),
        .iss_v0     (iss_v0),
        .iss_ins0   (iss_ins0),
        .iss_pc0    (iss_pc0),
        .iss_v1     (iss_v1),
        .iss_ins1   (iss_ins1),
        .iss_pc1    (iss_pc1),
        .count      (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] r_add(input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt);
        return {6'h00, rs, rt, rd, 5'h00, 6'h20};
    endfunction

    function automatic logic [31:0] i_beq(input logic [4:0] rs, input logic [4:0] rt);
        return {6'h04, rs, rt, 16'd4};
    endfunction

    function automatic logic [31:0] i_lw(input logic [4:0] rt, input logic [4:0] rs);
        return {6'h23, rs, rt, 16'd0};
    endfunction

    function automatic logic [31:0] wrap_ins(input logic [31:0] pc);
        logic [31:0] r;
        r = 32'd8 + (pc % 32'd20);
        return r_add(r[4:0], 5'd1, 5'd2);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] pc, input logic [31:0] i0, input logic [31:0] i1);
        f_valid = 1'b1;
        f_pc    = pc;
        f_ins0  = i0;
        f_ins1  = i1;
        step();
        f_valid = 1'b0;
    endtask

    initial begin
        int pushed;
        int issued;
        logic [31:0] exp_pc;
        logic st;
        logic acc;

        rst = 1'b1; f_valid = 1'b0; f_ins0 = '0; f_ins1 = '0; f_pc = '0;
        dual_en = 1'b1; ex_stall = 1'b0; br_resolve = 1'b0; br_taken = 1'b0;
        step();
        step();
        rst = 1'b0;
        chk("rst_v0", 32'(iss_v0), 32'd0);
        chk("rst_v1", 32'(iss_v1), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_ready", 32'(f_ready), 32'd1);
        chk("rst_ins0", iss_ins0, 32'd0);

        // independent pair
        push(32'd0, r_add(5'd3, 5'd1, 5'd2), r_add(5'd6, 5'd4, 5'd5));
        chk("ind_count1", 32'(count), 32'd2);
        chk("ind_v0_early", 32'(iss_v0), 32'd0);
        step();
        chk("ind_v0", 32'(iss_v0), 32'd1);
        chk("ind_v1", 32'(iss_v1), 32'd1);
        chk("ind_pc0", iss_pc0, 32'd0);
        chk("ind_pc1", iss_pc1, 32'd1);
        chk("ind_ins0", iss_ins0, r_add(5'd3, 5'd1, 5'd2));
        chk("ind_ins1", iss_ins1, r_add(5'd6, 5'd4, 5'd5));
        chk("ind_count", 32'(count), 32'd0);
        step();
        chk("ind_empty_v0", 32'(iss_v0), 32'd0);
        chk("ind_empty_pc0", iss_pc0, 32'd0);

        // RAW hazard
        push(32'd10, r_add(5'd3, 5'd1, 5'd2), r_add(5'd4, 5'd3, 5'd1));
        step();
        chk("raw_v0", 32'(iss_v0), 32'd1);
        chk("raw_v1", 32'(iss_v1), 32'd0);
        chk("raw_ins1_nop", iss_ins1, 32'd0);
        chk("raw_pc0", iss_pc0, 32'd10);
        chk("raw_count", 32'(count), 32'd1);
        step();
        chk("raw2_v0", 32'(iss_v0), 32'd1);
        chk("raw2_pc0", iss_pc0, 32'd11);
        chk("raw2_ins0", iss_ins0, r_add(5'd4, 5'd3, 5'd1));
        chk("raw2_v1", 32'(iss_v1), 32'd0);
        chk("raw2_count", 32'(count), 32'd0);

        // branch not taken
        push(32'd20, i_beq(5'd1, 5'd2), r_add(5'd3, 5'd1, 5'd2));
        push(32'd22, r_add(5'd6, 5'd4, 5'd5), r_add(5'd9, 5'd7, 5'd8));
        chk("brn_v0", 32'(iss_v0), 32'd1);
        chk("brn_ins0", iss_ins0, i_beq(5'd1, 5'd2));
        chk("brn_v1", 32'(iss_v1), 32'd0);
        chk("brn_count", 32'(count), 32'd3);
        step();
        chk("brn_wait_v0", 32'(iss_v0), 32'd0);
        step();
        chk("brn_wait2_v0", 32'(iss_v0), 32'd0);
        chk("brn_wait2_count", 32'(count), 32'd3);
        br_resolve = 1'b1; br_taken = 1'b0;
        step();
        br_resolve = 1'b0;
        chk("brn_res_v0", 32'(iss_v0), 32'd0);
        step();
        chk("brn_go_v0", 32'(iss_v0), 32'd1);
        chk("brn_go_pc0", iss_pc0, 32'd21);
        chk("brn_go_v1", 32'(iss_v1), 32'd1);
        chk("brn_go_pc1", iss_pc1, 32'd22);
        chk("brn_go_count", 32'(count), 32'd1);
        step();
        chk("brn_last_pc0", iss_pc0, 32'd23);
        chk("brn_last_v1", 32'(iss_v1), 32'd0);
        chk("brn_last_count", 32'(count), 32'd0);

        // branch taken, with an enqueue in the resolve cycle
        push(32'd30, i_beq(5'd1, 5'd2), r_add(5'd3, 5'd1, 5'd2));
        push(32'd32, r_add(5'd6, 5'd4, 5'd5), r_add(5'd9, 5'd7, 5'd8));
        chk("brt_pc0", iss_pc0, 32'd30);
        step();
        br_resolve = 1'b1; br_taken = 1'b1;
        push(32'd34, r_add(5'd6, 5'd4, 5'd5), r_add(5'd9, 5'd7, 5'd8));
        br_resolve = 1'b0; br_taken = 1'b0;
        chk("brt_count", 32'(count), 32'd0);
        chk("brt_v0", 32'(iss_v0), 32'd0);
        step();
        chk("brt_after_v0", 32'(iss_v0), 32'd0);
        chk("brt_after_count", 32'(count), 32'd0);

        // full queue under stall
        ex_stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            push(32'd40 + 32'(2 * i), r_add(5'(10 + 2 * i), 5'd1, 5'd2), r_add(5'(11 + 2 * i), 5'd1, 5'd2));
        end
        chk("full_count", 32'(count), 32'd8);
        chk("full_ready", 32'(f_ready), 32'd0);
        chk("full_v0", 32'(iss_v0), 32'd0);
        push(32'd48, r_add(5'd20, 5'd1, 5'd2), r_add(5'd21, 5'd1, 5'd2));
        chk("full_drop_count", 32'(count), 32'd8);
        ex_stall = 1'b0;
        step();
        chk("full_rel_pc0", iss_pc0, 32'd40);
        chk("full_rel_pc1", iss_pc1, 32'd41);
        chk("full_rel_count", 32'(count), 32'd6);
        chk("full_rel_ready", 32'(f_ready), 32'd1);
        step();
        chk("full_d1_pc0", iss_pc0, 32'd42);
        step();
        chk("full_d2_pc0", iss_pc0, 32'd44);
        step();
        chk("full_d3_pc1", iss_pc1, 32'd47);
        chk("full_d3_count", 32'(count), 32'd0);
        step();
        chk("full_end_v0", 32'(iss_v0), 32'd0);

        // MEM in slot 1 is held back
        push(32'd60, r_add(5'd3, 5'd1, 5'd2), i_lw(5'd5, 5'd6));
        step();
        chk("mem_v1", 32'(iss_v1), 32'd0);
        chk("mem_pc0", iss_pc0, 32'd60);
        step();
        chk("mem_lw_pc0", iss_pc0, 32'd61);
        chk("mem_lw_ins0", iss_ins0, i_lw(5'd5, 5'd6));

        // single issue mode
        dual_en = 1'b0;
        push(32'd70, r_add(5'd3, 5'd1, 5'd2), r_add(5'd6, 5'd4, 5'd5));
        step();
        chk("sgl_v1", 32'(iss_v1), 32'd0);
        chk("sgl_pc0", iss_pc0, 32'd70);
        step();
        chk("sgl2_pc0", iss_pc0, 32'd71);
        chk("sgl2_v1", 32'(iss_v1), 32'd0);
        dual_en = 1'b1;
        step();

        // wrap-around with random stalls
        pushed = 0;
        issued = 0;
        exp_pc = 32'd100;
        for (int cyc = 0; cyc < 600 && issued < 40; cyc++) begin
            st = ($urandom_range(0, 3) == 0);
            ex_stall = st;
            if (pushed < 20) begin
                f_valid = 1'b1;
                f_pc    = 32'd100 + 32'(2 * pushed);
                f_ins0  = wrap_ins(f_pc);
                f_ins1  = wrap_ins(f_pc + 32'd1);
            end else begin
                f_valid = 1'b0;
            end
            acc = f_valid && f_ready;
            step();
            if (acc) pushed++;
            if (!st) begin
                if (iss_v0) begin
                    chk("wrap_pc0", iss_pc0, exp_pc);
                    chk("wrap_ins0", iss_ins0, wrap_ins(exp_pc));
                    exp_pc = exp_pc + 32'd1;
                    issued++;
                end
                if (iss_v1) begin
                    chk("wrap_pc1", iss_pc1, exp_pc);
                    chk("wrap_ins1", iss_ins1, wrap_ins(exp_pc));
                    exp_pc = exp_pc + 32'd1;
                    issued++;
                end
            end
        end
        f_valid = 1'b0;
        ex_stall = 1'b0;
        chk("wrap_total", 32'(issued), 32'd40);
        step();
        chk("wrap_count", 32'(count), 32'd0);

        // asynchronous reset mid-stream
        push(32'd200, r_add(5'd3, 5'd1, 5'd2), r_add(5'd6, 5'd4, 5'd5));
        push(32'd202, r_add(5'd9, 5'd7, 5'd8), r_add(5'd12, 5'd10, 5'd11));
        chk("mid_v0", 32'(iss_v0), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_v0", 32'(iss_v0), 32'd0);
        chk("arst_v1", 32'(iss_v1), 32'd0);
        chk("arst_count", 32'(count), 32'd0);
        chk("arst_pc0", iss_pc0, 32'd0);
        step();
        rst = 1'b0;
        step();
        chk("post_rst_v0", 32'(iss_v0), 32'd0);
        chk("post_rst_ready", 32'(f_ready), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
